// File: rtl/staircase_pkg.sv
// Shared types and helpers for the staircase sequence scheduler.
// Holds the FSM state encoding and the repeat-target rule used by the generator.
package staircase_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } stc_state_e;

    // Value 0 is emitted once; every other value v is emitted v times.
    function automatic int unsigned stc_tgt(input int unsigned val);
        return (val == 0) ? 1 : val;
    endfunction

endpackage

// File: rtl/staircase_gen.sv
// Staircase datapath: walks val/rep up to a latched limit, one step per accepted beat.
// State is only meaningful while the owning scheduler is in RUN, so it carries no reset.
module staircase_gen
    import staircase_pkg::*;
#(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          load,
    input  logic [CW-1:0] load_lim,
    input  logic          adv,
    output logic [CW-1:0] val,
    output logic          last
);

    logic [CW-1:0] val_q, val_d;
    logic [CW-1:0] rep_q, rep_d;
    logic [CW-1:0] lim_q, lim_d;
    logic [CW:0]   tgt;
    logic [CW:0]   rep_inc;
    logic          rep_done;

    // rep+1 is formed one bit wider so val = 2^CW-1 still compares correctly.
    always_comb begin
        tgt      = (CW+1)'(stc_tgt(32'(val_q)));
        rep_inc  = {1'b0, rep_q} + 1'b1;
        rep_done = (rep_inc == tgt);
        last     = (val_q == lim_q) && rep_done;
        val      = val_q;
    end

    always_comb begin
        val_d = val_q;
        rep_d = rep_q;
        lim_d = lim_q;
        if (load) begin
            lim_d = load_lim;
            val_d = '0;
            rep_d = '0;
        end else if (adv && !last) begin
            if (rep_done) begin
                val_d = val_q + 1'b1;
                rep_d = '0;
            end else begin
                rep_d = rep_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        val_q <= val_d;
        rep_q <= rep_d;
        lim_q <= lim_d;
    end

endmodule

// File: rtl/staircase_seq_sched.sv
// Round-robin scheduler sharing one staircase generator among NREQ requesters.
// Optional STAIRCASE_SCHED_ABORT_EN adds an abort input that drops the running job.
module staircase_seq_sched
    import staircase_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int CW   = 5,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*CW-1:0] req_limit,
    output logic [NREQ-1:0]   req_ready,
`ifdef STAIRCASE_SCHED_ABORT_EN
    input  logic              abort,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CW-1:0]     out_value,
    output logic [IW-1:0]     out_id,
    output logic              out_last,
    output logic              busy
);

    stc_state_e    state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] id_q, id_d;

    logic          found;
    logic [IW-1:0] gidx;
    logic [IW-1:0] gnext;
    logic          grant;
    logic          adv;
    logic          abort_hit;
    logic [CW-1:0] load_lim;
    logic [CW-1:0] gen_val;
    logic          gen_last;

    // First valid requester at or after rr_ptr wins.
    always_comb begin
        int idx;
        int nxt;
        idx   = 0;
        nxt   = 0;
        found = 1'b0;
        gidx  = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(rr_ptr_q) + i) % NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                gidx  = IW'(idx);
            end
        end
        nxt   = (int'(gidx) + 1) % NREQ;
        gnext = IW'(nxt);
    end

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && found) begin
            req_ready[gidx] = 1'b1;
        end
    end

    assign grant    = (state_q == IDLE) && found;
    assign load_lim = req_limit[int'(gidx)*CW +: CW];
    assign busy     = (state_q == RUN);
    assign adv      = busy && out_ready;

`ifdef STAIRCASE_SCHED_ABORT_EN
    assign abort_hit = busy && abort;
`else
    assign abort_hit = 1'b0;
`endif

    staircase_gen #(
        .CW (CW)
    ) u_gen (
        .clk      (clk),
        .load     (grant),
        .load_lim (load_lim),
        .adv      (adv),
        .val      (gen_val),
        .last     (gen_last)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d  = RUN;
                    id_d     = gidx;
                    rr_ptr_d = gnext;
                end
            end
            RUN: begin
                if (abort_hit || (adv && gen_last)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        id_q <= id_d;
    end

    // Data is gated by RUN so outputs read zero in IDLE and after reset.
    assign out_valid = busy;
    assign out_value = busy ? gen_val : '0;
    assign out_id    = busy ? id_q : '0;
    assign out_last  = busy && gen_last;

endmodule

// File: tb/tb_staircase_seq_sched.sv
// Scoreboard bench for staircase_seq_sched: directed jobs push expected beats,
// a negedge monitor pops and compares every accepted beat and checks stall stability.
module tb_staircase_seq_sched;

    localparam int NREQ = 4;
    localparam int CW   = 5;
    localparam int IW   = 2;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*CW-1:0] req_limit;
    logic [NREQ-1:0]   req_ready;
    logic              abort;
    logic              out_valid;
    logic              out_ready;
    logic [CW-1:0]     out_value;
    logic [IW-1:0]     out_id;
    logic              out_last;
    logic              busy;

    always #5 clk = ~clk;

    staircase_seq_sched #(
        .NREQ (NREQ),
        .CW   (CW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_valid (req_valid),
        .req_limit (req_limit),
        .req_ready (req_ready),
`ifdef STAIRCASE_SCHED_ABORT_EN
        .abort     (abort),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value),
        .out_id    (out_id),
        .out_last  (out_last),
        .busy      (busy)
    );

    typedef struct packed {
        logic [CW-1:0] v;
        logic [IW-1:0] id;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    int    grant_cyc[$];
    int    grant_id[$];

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int beats = 0;
    int busy_cnt = 0;
    logic bp_en = 1'b0;
    logic stall_prev = 1'b0;
    logic [8:0] stall_snap = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_beat(input int v, input int id, input bit last);
        beat_t b;
        b.v    = CW'(v);
        b.id   = IW'(id);
        b.last = last;
        exp_q.push_back(b);
    endtask

    // Pushes a hand-written value list; the last entry carries out_last.
    task automatic push_list(input int id, input int vals[$], input bit ends);
        for (int k = 0; k < vals.size(); k++) begin
            push_beat(vals[k], id, ends && (k == vals.size() - 1));
        end
    endtask

    task automatic push_stairs(input int id, input int lim);
        int t;
        for (int v = 0; v <= lim; v++) begin
            t = (v == 0) ? 1 : v;
            for (int r = 0; r < t; r++) push_beat(v, id, (v == lim) && (r == t - 1));
        end
    endtask

    task automatic issue(input logic [NREQ-1:0] mask, input int lim);
        logic [NREQ-1:0] pending;
        logic [NREQ-1:0] g;
        int n;
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) if (mask[i]) req_limit[i*CW +: CW] = CW'(lim);
        req_valid = mask;
        pending = mask;
        n = 0;
        grant_cyc.delete();
        grant_id.delete();
        while (pending != 0 && n < 200) begin
            @(negedge clk);
            g = req_ready & pending;
            if (g != 0) begin
                chk("ready_onehot", $countones(req_ready), 1);
                for (int i = 0; i < NREQ; i++) if (g[i]) grant_id.push_back(i);
                grant_cyc.push_back(cyc);
            end
            @(posedge clk); #1;
            pending = pending & ~g;
            req_valid = pending;
            n++;
        end
        chk("grant_timeout", {28'd0, pending}, 0);
    endtask

    task automatic wait_drain(input int maxc);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("drain", {31'd0, (exp_q.size() != 0) || busy}, 0);
    endtask

    task automatic wait_beats(input int base, input int num);
        int n;
        n = 0;
        while ((beats - base) < num && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("beat_wait", beats - base, num);
    endtask

    // Monitor: compare accepted beats against the scoreboard, check hold under stall.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (stall_prev) chk("stall_hold", {23'd0, out_valid, out_value, out_id, out_last}, {23'd0, stall_snap});
                stall_prev = out_valid && !out_ready;
                stall_snap = {out_valid, out_value, out_id, out_last};
                if (busy) busy_cnt++;
                if (out_valid && out_ready) begin
                    beats++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", {24'd0, out_value, out_id, out_last}, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat", {24'd0, out_value, out_id, out_last}, {24'd0, e.v, e.id, e.last});
                    end
                end
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    initial begin
        int k;
        logic [3:0] pat;
        pat = 4'b1001;
        k = 0;
        forever begin
            @(posedge clk); #1;
            if (bp_en) begin
                out_ready = pat[k % 4];
                k++;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0;
        rstn = 1'b0;
        req_valid = '0;
        req_limit = '0;
        out_ready = 1'b1;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_value", out_value, 0);
        chk("rst_out_id", out_id, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_req_ready", req_ready, 0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // Requester 0, L=3: 0,1,2,2,3,3,3 back to back.
        push_list(0, '{0, 1, 2, 2, 3, 3, 3}, 1'b1);
        busy_cnt = 0;
        b0 = beats;
        issue(4'b0001, 3);
        @(negedge clk);
        chk("first_beat_latency", out_valid, 1);
        wait_drain(50);
        chk("l3_busy_cycles", busy_cnt, 7);
        chk("l3_beats", beats - b0, 7);
        chk("l3_grant_id", grant_id[0], 0);

        // L=0 from requester 3: single beat with last.
        push_list(3, '{0}, 1'b1);
        busy_cnt = 0;
        issue(4'b1000, 0);
        wait_drain(20);
        chk("l0_busy_cycles", busy_cnt, 1);

        // Simultaneous requesters 0,1,2 with L=1.
        push_list(0, '{0, 1}, 1'b1);
        push_list(1, '{0, 1}, 1'b1);
        push_list(2, '{0, 1}, 1'b1);
        issue(4'b0111, 1);
        wait_drain(50);
        chk("rr_grants", grant_id.size(), 3);
        if (grant_id.size() == 3) begin
            chk("rr_order0", grant_id[0], 0);
            chk("rr_order1", grant_id[1], 1);
            chk("rr_order2", grant_id[2], 2);
            chk("rr_gap01", grant_cyc[1] - grant_cyc[0], 3);
            chk("rr_gap12", grant_cyc[2] - grant_cyc[1], 3);
        end
        push_list(0, '{0, 1}, 1'b1);
        issue(4'b0001, 1);
        wait_drain(20);
        chk("rr_regrant0", grant_id[0], 0);

        // Backpressure on requester 2, L=2.
        push_list(2, '{0, 1, 2, 2}, 1'b1);
        bp_en = 1'b1;
        issue(4'b0100, 2);
        wait_drain(60);
        bp_en = 1'b0;
        out_ready = 1'b1;

        // Full-range limit from requester 3.
        push_stairs(3, 31);
        busy_cnt = 0;
        b0 = beats;
        issue(4'b1000, 31);
        wait_drain(700);
        chk("l31_busy_cycles", busy_cnt, 497);
        chk("l31_beats", beats - b0, 497);

        // Reset mid-job after 3 beats of L=4 from requester 1.
        push_list(1, '{0, 1, 2, 2, 3, 3, 3, 4, 4, 4, 4}, 1'b1);
        b0 = beats;
        issue(4'b0010, 4);
        wait_beats(b0, 3);
        @(posedge clk); #1;
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        exp_q.delete();
        @(posedge clk); #1;
        rstn = 1'b1;
        push_list(1, '{0, 1}, 1'b1);
        push_list(3, '{0, 1}, 1'b1);
        issue(4'b1010, 1);
        wait_drain(50);
        if (grant_id.size() == 2) begin
            chk("postrst_first", grant_id[0], 1);
            chk("postrst_second", grant_id[1], 3);
        end else begin
            chk("postrst_grants", grant_id.size(), 2);
        end

`ifdef STAIRCASE_SCHED_ABORT_EN
        // Abort after 2 beats: output drops with no last.
        push_list(2, '{0, 1, 2, 2, 3, 3, 3, 4, 4, 4, 4}, 1'b1);
        b0 = beats;
        issue(4'b0100, 4);
        wait_beats(b0, 2);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        exp_q.delete();
`endif

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
